// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: assembles SYNC/CMD_HI/CMD_LO/CHK byte frames from a UART receiver into a 16-bit command
// with a handshake, checksum check, overrun detection and an inter-byte timeout.
module rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    input  logic        cmd_ack,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        ovr_err
);
    typedef enum logic [1:0] {IDLE, HI, LO, CHK} state_t;

    state_t      st_q;
    logic [7:0]  hi_q, lo_q;
    logic [15:0] tmo_q, cmd_q;
    logic        clr_rdy_q, cmd_vld_q, chk_err_q, tmo_err_q, ovr_err_q;
    logic        accept, tmo_hit, sum_ok;

    // rx_rdy is still high during the clr_rdy cycle, so that cycle must not accept again
    assign accept  = rx_rdy && !clr_rdy_q;
    assign tmo_hit = (st_q != IDLE) && !accept && (tmo_q == TIMEOUT - 16'd1);
    assign sum_ok  = rx_data == 8'(hi_q + lo_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            clr_rdy_q <= 1'b0;
            cmd_vld_q <= 1'b0;
            chk_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            clr_rdy_q <= accept;
            chk_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            tmo_q     <= (st_q == IDLE || accept) ? '0 : tmo_q + 16'd1;
            if (cmd_ack)
                cmd_vld_q <= 1'b0;
            if (tmo_hit) begin
                st_q      <= IDLE;
                hi_q      <= '0;
                lo_q      <= '0;
                tmo_q     <= '0;
                tmo_err_q <= 1'b0 | 1'b1;
            end else if (accept) begin
                case (st_q)
                    IDLE: st_q <= (rx_data == SYNC_BYTE) ? HI : IDLE;
                    HI: begin
                        hi_q <= rx_data;
                        st_q <= LO;
                    end
                    LO: begin
                        lo_q <= rx_data;
                        st_q <= CHK;
                    end
                    CHK: begin
                        st_q <= IDLE;
                        if (!sum_ok)
                            chk_err_q <= 1'b1;
                        else if (!cmd_vld_q || cmd_ack) begin
                            cmd_q     <= {hi_q, lo_q};
                            cmd_vld_q <= 1'b1;
                        end else
                            ovr_err_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign clr_rdy = clr_rdy_q;
    assign cmd     = cmd_q;
    assign cmd_vld = cmd_vld_q;
    assign chk_err = chk_err_q;
    assign tmo_err = tmo_err_q;
    assign ovr_err = ovr_err_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames against rx_frame_ctrl with hand-computed commands and pulse counts.
module tb_rx_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        clr_rdy, cmd_vld, chk_err, tmo_err, ovr_err;
    logic [15:0] cmd;

    int checks = 0;
    int failures = 0;
    int n_clr = 0, n_chk = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;
    int b_clr, b_chk, b_tmo, b_ovr;

    rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT(16'd100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rdy(clr_rdy),
        .cmd(cmd), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack),
        .chk_err(chk_err), .tmo_err(tmo_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_clr   += int'(clr_rdy);
            n_chk   += int'(chk_err);
            n_tmo   += int'(tmo_err);
            n_ovr   += int'(ovr_err);
            n_multi += int'((32'(chk_err) + 32'(tmo_err) + 32'(ovr_err)) > 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_clr = n_clr;
        b_chk = n_chk;
        b_tmo = n_tmo;
        b_ovr = n_ovr;
    endtask

    task automatic send(input logic [7:0] b, input logic ack);
        int n;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        cmd_ack = ack;
        @(negedge clk);
        cmd_ack = 1'b0;
        n = 0;
        while (!clr_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!clr_rdy)
            check("clr_rdy_wait", 32'(clr_rdy), 32'd1);
        rx_rdy = 1'b0;
    endtask

    task automatic frame(input logic [31:0] f, input logic last_ack);
        send(f[31:24], 1'b0);
        send(f[23:16], 1'b0);
        send(f[15:8], 1'b0);
        send(f[7:0], last_ack);
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check("ack_clears_vld", 32'(cmd_vld), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_clr", 32'(clr_rdy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_vld", 32'(cmd_vld), 32'd0);
        check("rst_errs", {29'd0, chk_err, tmo_err, ovr_err}, 32'd0);
        rst = 1'b0;

        snap();
        frame(32'hA5123446, 1'b0);
        check("good_cmd", 32'(cmd), 32'h1234);
        check("good_vld", 32'(cmd_vld), 32'd1);
        check("good_clr_cnt", 32'(n_clr - b_clr), 32'd4);
        check("good_no_err", 32'((n_chk - b_chk) + (n_tmo - b_tmo) + (n_ovr - b_ovr)), 32'd0);
        ack();

        snap();
        frame(32'hA5123447, 1'b0);
        check("bad_chk_cnt", 32'(n_chk - b_chk), 32'd1);
        check("bad_vld", 32'(cmd_vld), 32'd0);
        check("bad_cmd_held", 32'(cmd), 32'h1234);
        frame(32'hA5FF0201, 1'b0);
        check("wrap_cmd", 32'(cmd), 32'hFF02);
        check("wrap_vld", 32'(cmd_vld), 32'd1);
        check("wrap_chk_cnt", 32'(n_chk - b_chk), 32'd1);
        ack();

        snap();
        send(8'h00, 1'b0);
        send(8'h7E, 1'b0);
        frame(32'hA5A5A54A, 1'b0);
        check("sync_data_cmd", 32'(cmd), 32'hA5A5);
        check("sync_data_vld", 32'(cmd_vld), 32'd1);
        check("sync_data_clr", 32'(n_clr - b_clr), 32'd6);
        check("sync_data_err", 32'(n_chk - b_chk), 32'd0);
        ack();

        snap();
        send(8'hA5, 1'b0);
        send(8'h12, 1'b0);
        repeat (150) @(negedge clk);
        check("tmo_cnt", 32'(n_tmo - b_tmo), 32'd1);
        frame(32'hA5010102, 1'b0);
        check("after_tmo_cmd", 32'(cmd), 32'h0101);
        check("after_tmo_vld", 32'(cmd_vld), 32'd1);
        check("after_tmo_chk", 32'(n_chk - b_chk), 32'd0);

        snap();
        frame(32'hA5123446, 1'b0);
        check("ovr_cnt", 32'(n_ovr - b_ovr), 32'd1);
        check("ovr_cmd_held", 32'(cmd), 32'h0101);
        check("ovr_vld", 32'(cmd_vld), 32'd1);
        frame(32'hA55678CE, 1'b1);
        check("ack_reload_cmd", 32'(cmd), 32'h5678);
        check("ack_reload_vld", 32'(cmd_vld), 32'd1);
        check("ack_reload_ovr", 32'(n_ovr - b_ovr), 32'd1);
        ack();

        snap();
        send(8'hA5, 1'b0);
        repeat (90) @(negedge clk);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h46, 1'b0);
        repeat (2) @(negedge clk);
        check("near_tmo_cnt", 32'(n_tmo - b_tmo), 32'd0);
        check("near_tmo_cmd", 32'(cmd), 32'h1234);
        ack();

        snap();
        frame(32'hA5123446, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd", 32'(cmd), 32'h0000);
        check("mid_rst_vld", 32'(cmd_vld), 32'd0);
        check("mid_rst_errs", {28'd0, clr_rdy, chk_err, tmo_err, ovr_err}, 32'd0);
        rst = 1'b0;
        snap();
        send(8'h46, 1'b0);
        repeat (3) @(negedge clk);
        check("post_rst_chk", 32'(n_chk - b_chk), 32'd0);
        check("post_rst_clr", 32'(n_clr - b_clr), 32'd1);
        check("post_rst_vld", 32'(cmd_vld), 32'd0);
        check("errs_exclusive", 32'(n_multi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, the maximum clocks allowed between accepted bytes inside a frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-006 SHALL have port rx_rdy  input  1  receiver byte-ready flag; held high until cleared.
REQ-007 SHALL have port clr_rdy  output  1  registered one-cycle pulse that knocks down rx_rdy.
REQ-008 SHALL have port cmd  output  16  last good command, {CMD_HI, CMD_LO}.
REQ-009 SHALL have port cmd_vld  output  1  high while cmd is unconsumed.
REQ-010 SHALL have port cmd_ack  input  1  consumer accepts cmd.
REQ-011 SHALL have port chk_err  output  1  one-cycle pulse on checksum mismatch.
REQ-012 SHALL have port tmo_err  output  1  one-cycle pulse on inter-byte timeout.
REQ-013 SHALL have port ovr_err  output  1  one-cycle pulse when a good frame is dropped because cmd_vld is held.

Function
REQ-014 SHALL define a frame as 4 bytes: SYNC_BYTE, CMD_HI, CMD_LO, CHK, with CHK = (CMD_HI + CMD_LO) mod 256.
REQ-015 SHALL accept a byte in a cycle where rx_rdy=1 and clr_rdy=0; it SHALL drive clr_rdy=1 on the next cycle for exactly one cycle.
REQ-016 SHALL never accept 2 bytes in consecutive cycles. The clr_rdy=1 cycle masks any stale rx_rdy.
REQ-017 SHALL implement the states IDLE, HI, LO and CHK.
REQ-018 IDLE: an accepted byte equal to SYNC_BYTE SHALL go to HI. Any other accepted byte SHALL be consumed and discarded, and the block SHALL stay in IDLE with no error.
REQ-019 HI: an accepted byte SHALL be stored as CMD_HI and the block SHALL go to LO. A SYNC_BYTE value here is data, not a resync.
REQ-020 LO: an accepted byte SHALL be stored as CMD_LO and the block SHALL go to CHK.
REQ-021 CHK: an accepted byte SHALL compare against the 8-bit sum and the block SHALL always return to IDLE.
REQ-022 On CHK match with cmd_vld=0 (or cmd_ack=1 in the same cycle), cmd SHALL load and cmd_vld SHALL be 1 the next cycle.
REQ-023 On CHK match with cmd_vld=1 and cmd_ack=0, the frame SHALL be dropped, cmd SHALL be held, and ovr_err SHALL pulse.
REQ-024 On CHK mismatch, chk_err SHALL pulse the next cycle and cmd/cmd_vld SHALL be unchanged.
REQ-025 cmd_ack while cmd_vld=1 SHALL clear cmd_vld next cycle, unless REQ-022 reloads in the same cycle. In that case cmd_vld SHALL stay 1 with the new cmd.
REQ-026 cmd_ack while cmd_vld=0 SHALL be ignored.
REQ-027 The timeout counter SHALL clear on every accepted byte and on entry to IDLE, and SHALL increment each cycle in HI, LO or CHK.
REQ-028 When the timeout counter reaches TIMEOUT-1 without an accepted byte, the block SHALL go to IDLE and tmo_err SHALL pulse next cycle. Partial CMD_HI/CMD_LO SHALL be discarded.
REQ-029 If a byte is accepted in the same cycle the counter reaches TIMEOUT-1, byte acceptance SHALL win and no timeout SHALL occur.
REQ-030 The checksum sum SHALL wrap modulo 256; no carry is retained.
REQ-031 chk_err, tmo_err and ovr_err SHALL be mutually exclusive per cycle and SHALL never pulse in the same cycle as clr_rdy of a different byte.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL enter IDLE and set clr_rdy=0, cmd=16'h0000, cmd_vld=0, chk_err=0, tmo_err=0, ovr_err=0, with the timeout counter cleared.
REQ-033 Reset mid-frame SHALL discard partial bytes. A byte pending on rx_rdy SHALL be accepted normally from the first cycle after rst falls.

Verification
REQ-034 Bytes A5,12,34,46 each with rx_rdy -> cmd=16'h1234, cmd_vld=1, one clr_rdy per byte, no error pulses.
REQ-035 Bytes A5,12,34,47 -> chk_err single pulse, cmd_vld stays 0, state IDLE; the following frame A5,FF,02,01 -> cmd=16'hFF02 (wraps).
REQ-036 Bytes 00,7E,A5,A5,A5,4A -> leading 00/7E discarded, cmd=16'hA5A5 (SYNC as data accepted), cmd_vld=1.
REQ-037 A5,12 then no byte for TIMEOUT (test override 100) cycles -> tmo_err pulse, IDLE; then A5,01,01,02 -> cmd=16'h0101.
REQ-038 Good frame with cmd_vld=1 and cmd_ack=0 -> ovr_err pulse, cmd held. The same with cmd_ack=1 on the CHK acceptance cycle -> cmd updated, cmd_vld stays 1, no ovr_err.
REQ-039 rst=1 asserted after A5,12,34 -> all outputs reset values; a subsequent 46 is discarded in IDLE with no chk_err.
